// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: owns the PC and runs one outstanding imem fetch at a time, handing {pc, instr} to decode.
// Optional PC_FETCH_MISALIGN_EN: misaligned PCs skip memory and present a NOP with fetch_misalign set.
module pc_fetch_unit #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr,
`ifdef PC_FETCH_MISALIGN_EN
  output logic            fetch_misalign,
`endif
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);
  typedef enum logic [1:0] {REQ, WAIT, OUT, DRAIN} state_t;
  state_t state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_inc;
  logic mis;
  logic hs;
`ifdef PC_FETCH_MISALIGN_EN
  assign mis = |pc[1:0];
`else
  assign mis = 1'b0;
`endif
  assign pc_inc = pc + XLEN'(4);
  assign imem_req_addr = pc;
  assign imem_req_valid = state == REQ && !rst && !mis;
  assign hs = imem_req_valid && imem_req_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= REQ;
      pc <= RESET_PC;
      if_valid <= 1'b0;
      if_pc <= '0;
      if_instr <= '0;
`ifdef PC_FETCH_MISALIGN_EN
      fetch_misalign <= 1'b0;
`endif
    end else begin
      if (redirect_valid) pc <= redirect_pc;
      case (state)
        REQ:
          if (redirect_valid) state <= hs ? DRAIN : REQ;
          else if (mis) begin
            state <= OUT;
            if_valid <= 1'b1;
            if_pc <= pc;
            if_instr <= XLEN'(32'h0000_0013);
`ifdef PC_FETCH_MISALIGN_EN
            fetch_misalign <= 1'b1;
`endif
          end else if (hs) state <= WAIT;
        WAIT:
          if (redirect_valid) state <= imem_resp_valid ? REQ : DRAIN;
          else if (imem_resp_valid) begin
            state <= OUT;
            if_valid <= 1'b1;
            if_pc <= pc;
            if_instr <= imem_resp_data;
          end
        OUT:
          if (redirect_valid || if_ready) begin
            state <= REQ;
            if_valid <= 1'b0;
`ifdef PC_FETCH_MISALIGN_EN
            fetch_misalign <= 1'b0;
`endif
            if (!redirect_valid) pc <= pc_inc;
          end
        DRAIN:
          if (imem_resp_valid) state <= REQ;
        default: state <= REQ;
      endcase
    end
  end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed scenarios with queued expected requests/outputs checked by a negedge monitor.
module tb_pc_fetch_unit;
  logic clk = 0, rst = 1;
  logic imem_req_valid, imem_req_ready = 0;
  logic [31:0] imem_req_addr;
  logic imem_resp_valid = 0;
  logic [31:0] imem_resp_data = 0;
  logic if_valid, if_ready = 0;
  logic [31:0] if_pc, if_instr;
  logic redirect_valid = 0;
  logic [31:0] redirect_pc = 0;
`ifdef PC_FETCH_MISALIGN_EN
  logic fetch_misalign;
`endif
  int passed = 0, total = 0, cyc = 0, mem_lat = 1, last_hs = -1;
  bit mem_bad = 0, gap_chk = 0;
  logic [31:0] exp_addr[$];
  logic [63:0] exp_out[$];

  pc_fetch_unit dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr),
`ifdef PC_FETCH_MISALIGN_EN
    .fetch_misalign(fetch_misalign),
`endif
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // memory: answers each accepted request mem_lat edges later with {addr[15:0],C0DE}
  initial forever begin
    @(negedge clk);
    if (imem_req_valid && imem_req_ready) begin
      logic [31:0] a;
      int l;
      a = imem_req_addr;
      l = mem_lat;
      repeat (l) @(posedge clk);
      #1 imem_resp_valid = 1;
      imem_resp_data = mem_bad ? 32'hDEAD_BEEF : {a[15:0], 16'hC0DE};
      mem_bad = 0;
      @(posedge clk);
      #1 imem_resp_valid = 0;
    end
  end

  initial forever begin
    @(negedge clk);
    if (imem_req_valid && imem_req_ready) begin
      if (exp_addr.size() == 0) begin
        total++;
        $display("FAIL unexpected_req: got addr %0h, none expected", imem_req_addr);
      end else chk("req_addr", {32'h0, imem_req_addr}, {32'h0, exp_addr.pop_front()});
      if (gap_chk && last_hs >= 0) chk("req_gap", 64'(cyc - last_hs), 64'd3);
      last_hs = cyc;
    end
    if (if_valid && if_ready) begin
      if (exp_out.size() == 0) begin
        total++;
        $display("FAIL unexpected_out: got pc %0h instr %0h, none expected", if_pc, if_instr);
      end else chk("out_pc_instr", {if_pc, if_instr}, exp_out.pop_front());
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  task automatic do_reset();
    rst = 1;
    redirect_valid = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_valid", {63'h0, imem_req_valid}, 64'h0);
    chk("rst_if_valid", {63'h0, if_valid}, 64'h0);
    chk("rst_if_pc_instr", {if_pc, if_instr}, 64'h0);
`ifdef PC_FETCH_MISALIGN_EN
    chk("rst_misalign", {63'h0, fetch_misalign}, 64'h0);
`endif
  endtask

  task automatic release_rst();
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("req_valid_after_rst", {63'h0, imem_req_valid}, 64'h1);
  endtask

  task automatic wait_valid();
    for (int n = 0; n < 50 && !if_valid; n++) @(negedge clk);
    chk("if_valid_seen", {63'h0, if_valid}, 64'h1);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_addr.size() != 0 || exp_out.size() != 0) && n < 100) begin
      @(negedge clk);
      #1 n++;
    end
    if (exp_addr.size() != 0 || exp_out.size() != 0) begin
      total++;
      $display("FAIL drain: got %0d reqs %0d outs pending, expected 0", exp_addr.size(), exp_out.size());
      exp_addr.delete();
      exp_out.delete();
    end
    @(posedge clk);
    #1 rst = 1;
  endtask

  initial begin
    // back-to-back fetches, one per 3 cycles
    imem_req_ready = 1; if_ready = 1;
    do_reset();
    exp_addr = '{32'h0, 32'h4, 32'h8};
    exp_out = '{{32'h0, 32'h0000_C0DE}, {32'h4, 32'h0004_C0DE}, {32'h8, 32'h0008_C0DE}};
    gap_chk = 1; last_hs = -1;
    release_rst();
    drain();
    gap_chk = 0;
    // decode stall
    if_ready = 0;
    do_reset();
    exp_addr = '{32'h0, 32'h4};
    exp_out = '{{32'h0, 32'h0000_C0DE}, {32'h4, 32'h0004_C0DE}};
    release_rst();
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      if (i != 0) @(negedge clk);
      chk("stall_pc_instr", {if_pc, if_instr}, {32'h0, 32'h0000_C0DE});
      chk("stall_no_req", {63'h0, imem_req_valid}, 64'h0);
    end
    @(posedge clk);
    #1 if_ready = 1;
    drain();
    // memory backpressure
    imem_req_ready = 0;
    do_reset();
    exp_addr = '{32'h0};
    exp_out = '{{32'h0, 32'h0000_C0DE}};
    release_rst();
    for (int i = 0; i < 4; i++) begin
      if (i != 0) @(negedge clk);
      chk("bp_req", {31'h0, imem_req_valid, imem_req_addr}, {31'h0, 1'b1, 32'h0});
    end
    @(posedge clk);
    #1 imem_req_ready = 1;
    drain();
    // redirect in WAIT, stale DEADBEEF dropped
    mem_lat = 3; mem_bad = 1;
    do_reset();
    exp_addr = '{32'h0, 32'h100};
    exp_out = '{{32'h100, 32'h0100_C0DE}};
    release_rst();
    @(posedge clk);
    #1 redirect_valid = 1; redirect_pc = 32'h100; mem_lat = 1;
    @(posedge clk);
    #1 redirect_valid = 0;
    @(negedge clk);
    chk("drain_no_req", {63'h0, imem_req_valid}, 64'h0);
    drain();
    // redirect in OUT while decode stalls
    if_ready = 0;
    do_reset();
    exp_addr = '{32'h0, 32'h200};
    exp_out = '{{32'h200, 32'h0200_C0DE}};
    release_rst();
    wait_valid();
    @(posedge clk);
    #1 redirect_valid = 1; redirect_pc = 32'h200;
    @(posedge clk);
    #1 redirect_valid = 0; if_ready = 1;
    @(negedge clk);
    chk("out_redirect_valid_drop", {63'h0, if_valid}, 64'h0);
    drain();
    // PC wrap via redirect of an unaccepted request
    imem_req_ready = 0;
    do_reset();
    exp_addr = '{32'hFFFF_FFFC, 32'h0};
    exp_out = '{{32'hFFFF_FFFC, 32'hFFFC_C0DE}, {32'h0, 32'h0000_C0DE}};
    release_rst();
    @(posedge clk);
    #1 redirect_valid = 1; redirect_pc = 32'hFFFF_FFFC;
    @(posedge clk);
    #1 redirect_valid = 0;
    @(negedge clk);
    chk("req_addr_redirected", {32'h0, imem_req_addr}, {32'h0, 32'hFFFF_FFFC});
    @(posedge clk);
    #1 imem_req_ready = 1;
    drain();
    // misaligned redirect target
    imem_req_ready = 0; if_ready = 0;
    do_reset();
`ifdef PC_FETCH_MISALIGN_EN
    exp_addr = '{32'h300};
    exp_out = '{{32'h102, 32'h0000_0013}, {32'h300, 32'h0300_C0DE}};
`else
    exp_addr = '{32'h102};
    exp_out = '{{32'h102, 32'h0102_C0DE}};
`endif
    release_rst();
    @(posedge clk);
    #1 redirect_valid = 1; redirect_pc = 32'h102;
    @(posedge clk);
    #1 redirect_valid = 0; imem_req_ready = 1;
`ifdef PC_FETCH_MISALIGN_EN
    wait_valid();
    chk("misalign_flag", {63'h0, fetch_misalign}, 64'h1);
    chk("misalign_nop", {32'h0, if_instr}, {32'h0, 32'h0000_0013});
    chk("misalign_no_req", {63'h0, imem_req_valid}, 64'h0);
    @(posedge clk);
    #1 redirect_valid = 1; redirect_pc = 32'h300; if_ready = 1;
    @(posedge clk);
    #1 redirect_valid = 0;
    @(negedge clk);
    chk("misalign_clear", {63'h0, fetch_misalign}, 64'h0);
`else
    if_ready = 1;
`endif
    drain();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
